vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 135 +++++++++++++
 tb/tb_vga_sync_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: a pixel-rate divider, h/v raster counters, sync and blank decode, and a frame counter.
// Optional macro VGA_SYNC_REG_EN registers the raster outputs (one clk latency); p_tick and frame_cnt are never delayed.
module vga_sync_gen #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int DIV    = 4,
   parameter bit HS_POL = 1'b0,
   parameter bit VS_POL = 1'b0,
   parameter int CW     = 10,
   parameter int FW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   output logic          p_tick,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          video_on,
   output logic          hsync,
   output logic          vsync,
   output logic          line_end,
   output logic          frame_start,
   output logic [FW-1:0] frame_cnt
);

   localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
   localparam logic [CW-1:0] H_MAX   = CW'(HT - 1);
   localparam logic [CW-1:0] V_MAX   = CW'(VT - 1);
   localparam logic [CW-1:0] H_VIS_C = CW'(H_VIS);
   localparam logic [CW-1:0] V_VIS_C = CW'(V_VIS);
   localparam logic [CW-1:0] HS_BEG  = CW'(H_VIS + H_FP);
   localparam logic [CW-1:0] HS_END  = CW'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_BEG  = CW'(V_VIS + V_FP);
   localparam logic [CW-1:0] VS_END  = CW'(V_VIS + V_FP + V_SYNC - 1);

   if (DIV < 1) begin : g_bad_div
      $error("vga_sync_gen: DIV must be 1 or more");
   end
   if ((longint'(HT) > (longint'(1) << CW)) || (longint'(VT) > (longint'(1) << CW))) begin : g_bad_cw
      $error("vga_sync_gen: HT-1 or VT-1 does not fit in CW bits");
   end

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          vo;
      logic          hs;
      logic          vs;
      logic          le;
      logic          fs;
   } raster_t;

   localparam raster_t RST_OUT = {{CW{1'b0}}, {CW{1'b0}}, 1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0};

   logic [DW-1:0] div_q;
   logic [CW-1:0] h_q;
   logic [CW-1:0] v_q;
   logic [FW-1:0] fc_q;
   logic          tick;
   logic          h_end;
   logic          v_end;
   raster_t       ras_c;
   raster_t       ras_o;

   assign tick  = ~rst & (div_q == DIV_MAX);
   assign h_end = (h_q == H_MAX);
   assign v_end = (v_q == V_MAX);

   // NOTE: state registers use non-blocking assignments so every counter sees pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
         fc_q  <= '0;
      end else begin
         div_q <= (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
         if (tick) begin
            if (h_end) begin
               h_q <= '0;
               if (v_end) begin
                  v_q  <= '0;
                  fc_q <= fc_q + 1'b1;
               end else begin
                  v_q <= v_q + 1'b1;
               end
            end else begin
               h_q <= h_q + 1'b1;
            end
         end
      end
   end

   // NOTE: every field is given a value before any condition, so this decode cannot infer a latch.
   always_comb begin
      ras_c.x  = h_q;
      ras_c.y  = v_q;
      ras_c.vo = (h_q < H_VIS_C) && (v_q < V_VIS_C);
      ras_c.hs = ((h_q >= HS_BEG) && (h_q <= HS_END)) ? HS_POL : ~HS_POL;
      ras_c.vs = ((v_q >= VS_BEG) && (v_q <= VS_END)) ? VS_POL : ~VS_POL;
      ras_c.le = tick && h_end;
      ras_c.fs = tick && (h_q == '0) && (v_q == '0);
      // Reset is synchronous, so the counters may still hold stale values in the reset cycle itself.
      if (rst) ras_c = RST_OUT;
   end

`ifdef VGA_SYNC_REG_EN
   always_ff @(posedge clk) begin
      if (rst) ras_o <= RST_OUT;
      else     ras_o <= ras_c;
   end
`else
   assign ras_o = ras_c;
`endif

   assign p_tick      = tick;
   assign pixel_x     = ras_o.x;
   assign pixel_y     = ras_o.y;
   assign video_on    = ras_o.vo;
   assign hsync       = ras_o.hs;
   assign vsync       = ras_o.vs;
   assign line_end    = ras_o.le;
   assign frame_start = ras_o.fs;
   assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing, a tiny DIV=1 raster and a tiny DIV=4 raster.
// Cycle k counts clks after rst is released; raster outputs are expected LAT clks after the counter state.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       pt_a, vo_a, hs_a, vs_a, le_a, fs_a;
   logic [9:0] px_a, py_a;
   logic [7:0] fc_a;
   logic       pt_b, vo_b, hs_b, vs_b, le_b, fs_b;
   logic [9:0] px_b, py_b;
   logic [7:0] fc_b;
   logic       pt_c, vo_c, hs_c, vs_c, le_c, fs_c;
   logic [9:0] px_c, py_c;
   logic [7:0] fc_c;

   vga_sync_gen dut_a (
      .clk(clk), .rst(rst), .p_tick(pt_a), .pixel_x(px_a), .pixel_y(py_a), .video_on(vo_a),
      .hsync(hs_a), .vsync(vs_a), .line_end(le_a), .frame_start(fs_a), .frame_cnt(fc_a)
   );

   vga_sync_gen #(
      .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .DIV(1), .HS_POL(1'b1)
   ) dut_b (
      .clk(clk), .rst(rst), .p_tick(pt_b), .pixel_x(px_b), .pixel_y(py_b), .video_on(vo_b),
      .hsync(hs_b), .vsync(vs_b), .line_end(le_b), .frame_start(fs_b), .frame_cnt(fc_b)
   );

   vga_sync_gen #(
      .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut_c (
      .clk(clk), .rst(rst), .p_tick(pt_c), .pixel_x(px_c), .pixel_y(py_c), .video_on(vo_c),
      .hsync(hs_c), .vsync(vs_c), .line_end(le_c), .frame_start(fs_c), .frame_cnt(fc_c)
   );

   typedef struct {
      int sel;
      int k;
      bit pt;
      int x;
      int y;
      bit hs;
      bit vs;
      bit vo;
      bit le;
      bit fs;
   } vec_t;

   typedef struct packed {
      logic       pt;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       le;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   int   n_vec = 0;
   int   n_bad = 0;
   int   cur   = -1;
   vec_t tbl[$];

   function automatic vec_t mk(input int sel, input int k, input bit pt, input int x, input int y,
                               input bit hs, input bit vs, input bit vo, input bit le, input bit fs);
      vec_t e;
      e.sel = sel; e.k = k; e.pt = pt; e.x = x; e.y = y;
      e.hs = hs; e.vs = vs; e.vo = vo; e.le = le; e.fs = fs;
      return e;
   endfunction

   function automatic obs_t sample(input int sel);
      obs_t o;
      case (sel)
         0:       o = {pt_a, px_a, py_a, hs_a, vs_a, vo_a, le_a, fs_a, fc_a};
         1:       o = {pt_b, px_b, py_b, hs_b, vs_b, vo_b, le_b, fs_b, fc_b};
         default: o = {pt_c, px_c, py_c, hs_c, vs_c, vo_c, le_c, fs_c, fc_c};
      endcase
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance to the middle (negedge) of cycle k.
   task automatic wait_to(input int k);
      while (cur < k) begin
         @(negedge clk);
         cur++;
      end
   endtask

   task automatic check_idle(input string tag, input obs_t o, input bit hs_idle, input bit vs_idle);
      check({tag, " p_tick"}, o.pt, 0);
      check({tag, " pixel_x"}, o.x, 0);
      check({tag, " pixel_y"}, o.y, 0);
      check({tag, " video_on"}, o.vo, 0);
      check({tag, " hsync"}, o.hs, hs_idle);
      check({tag, " vsync"}, o.vs, vs_idle);
      check({tag, " line_end"}, o.le, 0);
      check({tag, " frame_start"}, o.fs, 0);
      check({tag, " frame_cnt"}, o.fc, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("rst a", sample(0), 1'b1, 1'b1);
      check_idle("rst b", sample(1), 1'b0, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      cur = -1;
   endtask

   task automatic apply(input vec_t e);
      obs_t  o;
      string t;
      t = $sformatf("dut%0d k=%0d", e.sel, e.k);
      wait_to(e.k);
      o = sample(e.sel);
      check({t, " p_tick"}, o.pt, e.pt);
      wait_to(e.k + LAT);
      o = sample(e.sel);
      check({t, " pixel_x"}, o.x, e.x);
      check({t, " pixel_y"}, o.y, e.y);
      check({t, " hsync"}, o.hs, e.hs);
      check({t, " vsync"}, o.vs, e.vs);
      check({t, " video_on"}, o.vo, e.vo);
      check({t, " line_end"}, o.le, e.le);
      check({t, " frame_start"}, o.fs, e.fs);
   endtask

   initial begin
      int   hs_low_a, le_cnt_a, pt_cnt_a, pt_cnt_b, hs_hi_b, vo_cnt_c, vo_tick_c, vs_low_c;
      int   fs_b0, fs_b1, fs_c0, fs_c1;
      obs_t o;

      //            sel  k    pt  x    y  hs vs vo le fs   (640x480, DIV=4)
      tbl.push_back(mk(0, 0,    0, 0,   0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2,    0, 0,   0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 3,    1, 0,   0, 1, 1, 1, 0, 1));
      tbl.push_back(mk(0, 4,    0, 1,   0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2559, 1, 639, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2560, 0, 640, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2623, 1, 655, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2624, 0, 656, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 3007, 1, 751, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 3008, 0, 752, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 3198, 0, 799, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 3199, 1, 799, 0, 1, 1, 0, 1, 0));
      tbl.push_back(mk(0, 3200, 0, 0,   1, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 3203, 1, 0,   1, 1, 1, 1, 0, 0));
      //            (14x7 raster, DIV=1, HS_POL=1)
      tbl.push_back(mk(1, 0,  1, 0,  0, 0, 1, 1, 0, 1));
      tbl.push_back(mk(1, 7,  1, 7,  0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 8,  1, 8,  0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 9,  1, 9,  0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 10, 1, 10, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 11, 1, 11, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 12, 1, 12, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 13, 1, 13, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(1, 14, 1, 0,  1, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 55, 1, 13, 3, 0, 1, 0, 1, 0));
      tbl.push_back(mk(1, 56, 1, 0,  4, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 70, 1, 0,  5, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 83, 1, 13, 5, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 84, 1, 0,  6, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 97, 1, 13, 6, 0, 1, 0, 1, 0));
      tbl.push_back(mk(1, 98, 1, 0,  0, 0, 1, 1, 0, 1));

      do_reset();
      foreach (tbl[i]) if (tbl[i].sel == 0) apply(tbl[i]);

      do_reset();
      foreach (tbl[i]) if (tbl[i].sel == 1) apply(tbl[i]);

      // frame_cnt reaches 255 after 255 frames of 98 clks, then wraps with the raster.
      wait_to(98 * 255);
      check("fc b before wrap", fc_b, 255);
      wait_to(98 * 256 - 1);
      check("fc b last pixel", fc_b, 255);
      wait_to(98 * 256 - 1 + LAT);
      o = sample(1);
      check("wrap b last x", o.x, 13);
      check("wrap b last y", o.y, 6);
      check("wrap b line_end", o.le, 1);
      wait_to(98 * 256);
      check("fc b wrapped", fc_b, 0);
      wait_to(98 * 256 + LAT);
      o = sample(1);
      check("wrap b x", o.x, 0);
      check("wrap b y", o.y, 0);
      check("wrap b frame_start", o.fs, 1);

      // Counting pass over one default line and whole frames of the small rasters.
      do_reset();
      hs_low_a = 0; le_cnt_a = 0; pt_cnt_a = 0; pt_cnt_b = 0; hs_hi_b = 0;
      vo_cnt_c = 0; vo_tick_c = 0; vs_low_c = 0;
      fs_b0 = -1; fs_b1 = -1; fs_c0 = -1; fs_c1 = -1;
      for (int i = 0; i <= 3200; i++) begin
         wait_to(i);
         if (!hs_a) hs_low_a++;
         if (le_a) le_cnt_a++;
         if (pt_a) pt_cnt_a++;
         if (i < 98 && pt_b) pt_cnt_b++;
         if (i >= LAT && i < 98 + LAT && hs_b) hs_hi_b++;
         if (i >= LAT && i < 392 + LAT) begin
            if (vo_c) vo_cnt_c++;
            if (vo_c && pt_c) vo_tick_c++;
            if (!vs_c) vs_low_c++;
         end
         if (fs_b) begin
            if (fs_b0 < 0) fs_b0 = i;
            else if (fs_b1 < 0) fs_b1 = i;
         end
         if (fs_c) begin
            if (fs_c0 < 0) fs_c0 = i;
            else if (fs_c1 < 0) fs_c1 = i;
         end
      end
      check("a hsync low clks per line", hs_low_a, 384);
      check("a line_end pulses", le_cnt_a, 1);
      check("a p_ticks per line", pt_cnt_a, 800);
      check("b p_tick every clk", pt_cnt_b, 98);
      check("b hsync high clks per frame", hs_hi_b, 14);
      check("c video_on clks per frame", vo_cnt_c, 128);
      check("c video_on pixels per frame", vo_tick_c, 32);
      check("c vsync low clks per frame", vs_low_c, 56);
      check("b first frame_start", fs_b0, LAT);
      check("b frame period", fs_b1 - fs_b0, 98);
      check("c first frame_start", fs_c0, 3 + LAT);
      check("c frame period", fs_c1 - fs_c0, 392);

      // Mid-frame reset on the tick clk of pixel (5,2), then restart from (0,0).
      do_reset();
      wait_to(135);
      check("c pre-rst p_tick", pt_c, 1);
      check("c pre-rst x", px_c, 5);
      check("c pre-rst y", py_c, 2);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_idle("mid rst c", sample(2), 1'b1, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      cur = -1;
      wait_to(2);
      check("c restart p_tick k=2", pt_c, 0);
      wait_to(3);
      check("c restart p_tick k=3", pt_c, 1);
      wait_to(3 + LAT);
      o = sample(2);
      check("c restart x", o.x, 0);
      check("c restart y", o.y, 0);
      check("c restart frame_start", o.fs, 1);
      check("c restart video_on", o.vo, 1);
      wait_to(4 + LAT);
      check("c restart x advance", px_c, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
